// File: rtl/cl_ocl_cfg_xbar.sv
// AXI-Lite to cfg-bus decoder for the OCL BAR: one transaction at a time, routed to
// one of NUM_SLV cfg channels by address window, with read/write fairness and ack timeout.
module cl_ocl_cfg_xbar #(
  parameter int unsigned NUM_SLV     = 16,
  parameter int unsigned SEL_LSB     = 8,
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter logic [31:0] DEAD_DATA   = 32'hDEAD_BEEF
) (
  input  logic                   clk,
  input  logic                   sync_rst_n,
  input  logic                   flr_assert,
  input  logic [31:0]            s_awaddr,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [31:0]            s_wdata,
  input  logic [3:0]             s_wstrb,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  output logic [1:0]             s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready,
  input  logic [31:0]            s_araddr,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  output logic [31:0]            s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rvalid,
  input  logic                   s_rready,
  output logic [31:0]            cfg_addr,
  output logic [31:0]            cfg_wdata,
  output logic [3:0]             cfg_wstrb,
  output logic [NUM_SLV-1:0]     cfg_wr,
  output logic [NUM_SLV-1:0]     cfg_rd,
  input  logic [NUM_SLV-1:0]     cfg_ack,
  input  logic [NUM_SLV*32-1:0]  cfg_rdata,
  output logic [15:0]            err_cnt,
  output logic                   busy
);

  localparam int unsigned IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  localparam int unsigned SEL_W = 32 - SEL_LSB;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CYC, ST_RESP} state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_last_wr;
  logic               r_is_wr;
  logic               r_hit;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_tmo;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wstrb;
  logic [NUM_SLV-1:0] r_cfg_wr;
  logic [NUM_SLV-1:0] r_cfg_rd;
  logic               r_bvalid;
  logic [1:0]         r_bresp;
  logic               r_rvalid;
  logic [1:0]         r_rresp;
  logic [31:0]        r_rdata;
  logic [15:0]        r_err_cnt;

  logic               w_can_gnt;
  logic               w_gnt_wr;
  logic               w_gnt_rd;
  logic [31:0]        w_gnt_addr;
  logic [SEL_W-1:0]   w_sel;
  logic               w_hit;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [NUM_SLV-1:0] w_onehot;
  logic               w_ack;
  logic [31:0]        w_slot_rdata;
  logic               w_done;
  logic [1:0]         w_resp;
  logic [31:0]        w_data;

  // Grant only from IDLE; on contention the type not granted last wins
  assign w_can_gnt  = (r_state == ST_IDLE) & sync_rst_n & ~flr_assert;
  assign w_gnt_wr   = w_can_gnt & s_awvalid & s_wvalid & (~s_arvalid | ~r_last_wr);
  assign w_gnt_rd   = w_can_gnt & s_arvalid & ~w_gnt_wr;
  assign w_gnt_addr = w_gnt_wr ? s_awaddr : s_araddr;
  assign w_sel      = w_gnt_addr[31:SEL_LSB];
  assign w_hit      = 64'(w_sel) < 64'(NUM_SLV);
  assign w_sel_idx  = IDX_W'(w_sel);
  assign w_onehot   = NUM_SLV'(1) << w_sel_idx;

  assign w_ack        = r_hit & cfg_ack[r_idx];
  assign w_slot_rdata = cfg_rdata[{r_idx, 5'd0} +: 32];

  // Completion decision while in CYC; ack takes priority over the timeout flag
  always_comb begin
    w_done = 1'b0;
    w_resp = 2'b00;
    w_data = DEAD_DATA;
    if (r_state == ST_CYC) begin
      if (!r_hit) begin
        w_done = 1'b1;
        w_resp = 2'b11;
      end else if (w_ack) begin
        w_done = 1'b1;
        w_data = w_slot_rdata;
      end else if (r_tmo) begin
        w_done = 1'b1;
        w_resp = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_last_wr <= 1'b0;
      r_is_wr   <= 1'b0;
      r_hit     <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_tmo     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_cfg_wr  <= '0;
      r_cfg_rd  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_rvalid  <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
      r_err_cnt <= '0;
    end else begin
      r_cfg_wr <= '0;
      r_cfg_rd <= '0;
      if (flr_assert) begin
        r_state  <= ST_IDLE;
        r_busy   <= 1'b0;
        r_bvalid <= 1'b0;
        r_bresp  <= 2'b00;
        r_rvalid <= 1'b0;
        r_rresp  <= 2'b00;
        r_cnt    <= '0;
        r_tmo    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_gnt_wr || w_gnt_rd) begin
              r_state   <= ST_CYC;
              r_busy    <= 1'b1;
              r_last_wr <= w_gnt_wr;
              r_is_wr   <= w_gnt_wr;
              r_addr    <= w_gnt_addr;
              r_hit     <= w_hit;
              r_idx     <= w_sel_idx;
              r_cnt     <= '0;
              r_tmo     <= 1'b0;
              if (w_gnt_wr) begin
                r_wdata <= s_wdata;
                r_wstrb <= s_wstrb;
              end
              if (w_hit && w_gnt_wr) r_cfg_wr <= w_onehot;
              if (w_hit && w_gnt_rd) r_cfg_rd <= w_onehot;
            end
          end
          ST_CYC: begin
            if (w_done) begin
              r_state <= ST_RESP;
              if (r_is_wr) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_resp;
              end else begin
                r_rvalid <= 1'b1;
                r_rresp  <= w_resp;
                r_rdata  <= w_data;
              end
              if ((w_resp != 2'b00) && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
            end else if (r_cnt == CNT_MAX) begin
              // Timeout is flagged here and resolved next cycle, giving a late ack one more chance
              r_tmo <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_RESP: begin
            if ((r_bvalid && s_bready) || (r_rvalid && s_rready)) begin
              r_state  <= ST_IDLE;
              r_busy   <= 1'b0;
              r_bvalid <= 1'b0;
              r_bresp  <= 2'b00;
              r_rvalid <= 1'b0;
              r_rresp  <= 2'b00;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign s_awready = w_gnt_wr;
  assign s_wready  = w_gnt_wr;
  assign s_arready = w_gnt_rd;
  assign s_bvalid  = r_bvalid;
  assign s_bresp   = r_bresp;
  assign s_rvalid  = r_rvalid;
  assign s_rresp   = r_rresp;
  assign s_rdata   = r_rdata;
  assign cfg_addr  = r_addr;
  assign cfg_wdata = r_wdata;
  assign cfg_wstrb = r_wstrb;
  assign cfg_wr    = r_cfg_wr;
  assign cfg_rd    = r_cfg_rd;
  assign err_cnt   = r_err_cnt;
  assign busy      = r_busy;

endmodule

// File: tb/tb_cl_ocl_cfg_xbar.sv
// Bench for cl_ocl_cfg_xbar: directed scenarios then randomized transactions,
// each checked against latency/response rules computed from address, ack delay and history.
module tb_cl_ocl_cfg_xbar;

  localparam int NSLV = 16;
  localparam int TMO  = 256;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  logic               clk;
  logic               sync_rst_n;
  logic               flr_assert;
  logic [31:0]        s_awaddr;
  logic               s_awvalid;
  logic               s_awready;
  logic [31:0]        s_wdata;
  logic [3:0]         s_wstrb;
  logic               s_wvalid;
  logic               s_wready;
  logic [1:0]         s_bresp;
  logic               s_bvalid;
  logic               s_bready;
  logic [31:0]        s_araddr;
  logic               s_arvalid;
  logic               s_arready;
  logic [31:0]        s_rdata;
  logic [1:0]         s_rresp;
  logic               s_rvalid;
  logic               s_rready;
  logic [31:0]        cfg_addr;
  logic [31:0]        cfg_wdata;
  logic [3:0]         cfg_wstrb;
  logic [NSLV-1:0]    cfg_wr;
  logic [NSLV-1:0]    cfg_rd;
  logic [NSLV-1:0]    cfg_ack;
  logic [NSLV*32-1:0] cfg_rdata;
  logic [15:0]        err_cnt;
  logic               busy;

  int checks = 0;
  int errors = 0;
  bit m_last_wr = 1'b0;
  int m_err = 0;

  cl_ocl_cfg_xbar #(
    .NUM_SLV(NSLV), .SEL_LSB(8), .TIMEOUT_CYC(TMO), .DEAD_DATA(DEAD)
  ) dut (
    .clk(clk), .sync_rst_n(sync_rst_n), .flr_assert(flr_assert),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_wstrb(cfg_wstrb),
    .cfg_wr(cfg_wr), .cfg_rd(cfg_rd), .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata),
    .err_cnt(err_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction; caller and return point are 1 time unit after a rising edge with the DUT idle
  task automatic do_txn(input bit is_wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input int dly, input logic [31:0] rd_val,
                        input bit noise, input int rdy_dly, input int flr_k);
    int idx;
    bit hit;
    bit acked;
    int lat;
    int got;
    logic [1:0] eresp;
    logic [31:0] edata;
    logic [15:0] oh;
    idx   = int'(addr >> 8);
    hit   = (idx < NSLV);
    acked = hit && (dly >= 0) && (dly <= TMO);
    lat   = !hit ? 2 : (acked ? 2 + dly : TMO + 2);
    eresp = !hit ? 2'b11 : (acked ? 2'b00 : 2'b10);
    edata = acked ? rd_val : DEAD;
    oh    = hit ? (16'(1) << idx) : 16'h0;
    got   = -1;
    if (hit) cfg_rdata[idx*32 +: 32] = rd_val;

    if (is_wr) begin
      s_awaddr = addr; s_wdata = wd; s_wstrb = ws; s_awvalid = 1'b1; s_wvalid = 1'b1;
    end else begin
      s_araddr = addr; s_arvalid = 1'b1;
    end
    #1;
    chk("gnt", {s_awready, s_wready, s_arready}, is_wr ? 3'b110 : 3'b001);
    m_last_wr = is_wr;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;

    for (int k = 1; k <= TMO + 20; k++) begin
      cfg_ack = '0;
      if (hit && (dly == k - 1)) cfg_ack[idx] = 1'b1;
      if (noise) cfg_ack[(idx + 1) % NSLV] = 1'b1;
      if (k == flr_k) flr_assert = 1'b1;
      if (k == 1) begin
        chk("pulse", {cfg_wr, cfg_rd}, is_wr ? {oh, 16'h0} : {16'h0, oh});
        chk("cfg_addr", cfg_addr, addr);
        if (is_wr) chk("cfg_wdata", {cfg_wstrb, cfg_wdata}, {ws, wd});
      end
      if (k == 2) chk("pulse_end", {cfg_wr, cfg_rd}, 32'h0);
      if (is_wr ? s_bvalid : s_rvalid) begin
        got = k;
        break;
      end
      tick();
      if (k == flr_k) begin
        flr_assert = 1'b0;
        cfg_ack = '0;
        chk("flr_busy", busy, 1'b0);
        for (int j = 0; j < 4; j++) begin
          chk("flr_novalid", {s_bvalid, s_rvalid}, 2'b00);
          tick();
        end
        chk("flr_err", err_cnt, 16'(m_err));
        return;
      end
    end
    cfg_ack = '0;
    if (eresp != 2'b00 && m_err < 65535) m_err++;
    chk("latency", got, lat);
    chk("resp", is_wr ? s_bresp : s_rresp, eresp);
    if (!is_wr) chk("rdata", s_rdata, edata);
    chk("err_cnt", err_cnt, 16'(m_err));
    chk("busy_resp", busy, 1'b1);

    for (int j = 0; j < rdy_dly; j++) begin
      tick();
      chk("valid_hold", is_wr ? s_bvalid : s_rvalid, 1'b1);
    end
    if (is_wr) s_bready = 1'b1; else s_rready = 1'b1;
    tick();
    s_bready = 1'b0; s_rready = 1'b0;
    chk("resp_clear", {s_bvalid, s_rvalid, s_bresp, s_rresp, busy}, 7'h0);
  endtask

  initial begin
    int n;
    int r;
    int idx;
    int dly;
    bit w;
    logic [31:0] a;

    sync_rst_n = 1'b0; flr_assert = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    cfg_ack = '0;
    for (int i = 0; i < NSLV; i++) cfg_rdata[i*32 +: 32] = 32'hCAFE_0000 | 32'(i);

    // Reset: everything low even with requests pending
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    repeat (3) tick();
    chk("rst_ready", {s_awready, s_wready, s_arready}, 3'b000);
    chk("rst_valid", {s_bvalid, s_rvalid, busy}, 3'b000);
    chk("rst_cfg", {cfg_addr, cfg_wr, cfg_rd, err_cnt}, 64'h0);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    sync_rst_n = 1'b1;
    tick();

    // Contention: all request valids held, every channel acks at once
    s_awaddr = 32'h0000_0004; s_wdata = 32'h0BAD_F00D; s_wstrb = 4'h3;
    s_araddr = 32'h0000_0108;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    s_bready = 1'b1; s_rready = 1'b1; cfg_ack = '1;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      #1;
      if (s_awready || s_arready) begin
        chk("arb_excl", s_awready & s_arready, 1'b0);
        chk("arb_order", s_awready, !m_last_wr);
        m_last_wr = s_awready;
        n++;
      end
      tick();
      if (n == 4) begin
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
      end
    end
    chk("arb_count", n, 4);
    for (int c = 0; c < 10 && busy; c++) tick();
    chk("arb_idle", {busy, err_cnt}, 17'h0);
    cfg_ack = '0; s_bready = 1'b0; s_rready = 1'b0;
    tick();

    do_txn(1'b1, 32'h0000_0304, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b0, 0, -1);
    do_txn(1'b0, 32'h0000_0510, 32'h0, 4'h0, 3, 32'hCAFE_0005, 1'b0, 0, -1);
    do_txn(1'b0, 32'h0000_1000, 32'h0, 4'h0, 0, 32'h0, 1'b0, 0, -1);
    chk("decerr_cnt", err_cnt, 16'd1);
    do_txn(1'b1, 32'h0000_0200, 32'hA5A5_5A5A, 4'h5, -1, 32'h0, 1'b1, 1, -1);

    // Late ack on channel 2 after its timeout must not start anything
    cfg_ack[2] = 1'b1;
    tick();
    cfg_ack = '0;
    chk("late_ack", {busy, s_bvalid, s_rvalid, cfg_wr, cfg_rd}, 35'h0);
    chk("late_ack_err", err_cnt, 16'(m_err));

    do_txn(1'b1, 32'h0000_0100, 32'h1111_2222, 4'hF, -1, 32'h0, 1'b0, 0, 3);
    do_txn(1'b0, 32'h0000_0140, 32'h0, 4'h0, 1, 32'h7777_0001, 1'b0, 0, -1);

    for (int t = 0; t < 24; t++) begin
      w   = 1'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 17));
      a   = (32'(idx) << 8) | (32'($urandom_range(0, 63)) << 2);
      r   = int'($urandom_range(0, 11));
      dly = (r >= 10) ? -1 : r;
      do_txn(w, a, $urandom, 4'($urandom_range(0, 15)), dly, $urandom,
             1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
